// File: rtl/cp0_regfile.sv
// cp0_regfile -- Coprocessor-0 register file (Status/Cause/EPC) for Minisys-1A.
//
// Holds Status (reg 12), Cause (reg 13) and EPC (reg 14). Applies decode-stage
// writes (exception entry, eret, mtc0), latches rising edges on the external
// interrupt lines into Cause IP[15:10], and raises Interrupt_request to fetch.
//
// Ports:
//   clock, reset               - rising-edge clock, async active-low reset
//   Status/Cause/EPC_write     - load enables, with matching *_write_data
//   Interrupt_in[5:0]          - async, edge-triggered interrupt lines
//   Interrupt_ack, PC_interrupt- fetch is taking the interrupt; return address
//   *_read_data                - current register contents (no bypass)
//   Interrupt_request          - enabled, unmasked interrupt pending

// Per-line synchroniser: two metastability flops plus a history flop.
// rise pulses for exactly one cycle per low-to-high transition seen by s2.
module cp0_irq_sync (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);
   logic s1, s2, h;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         h  <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         h  <= s2;
      end
   end

   assign rise = s2 & ~h;
endmodule

module cp0_regfile #(
   parameter int IRQ_LINES = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 Status_write,
   input  logic [31:0]          Status_write_data,
   input  logic                 Cause_write,
   input  logic [31:0]          Cause_write_data,
   input  logic                 EPC_write,
   input  logic [31:0]          EPC_write_data,
   input  logic [IRQ_LINES-1:0] Interrupt_in,
   input  logic                 Interrupt_ack,
   input  logic [31:0]          PC_interrupt,
   output logic [31:0]          Status_read_data,
   output logic [31:0]          Cause_read_data,
   output logic [31:0]          EPC_read_data,
   output logic                 Interrupt_request
);
   localparam int IP_LO = 10;

   logic [31:0]          status_q, cause_q, epc_q;
   logic [IRQ_LINES-1:0] rise;
   logic                 any_write, ack_take;

   genvar gi;
   generate
      for (gi = 0; gi < IRQ_LINES; gi++) begin : g_sync
         cp0_irq_sync u_sync (
            .clock (clock),
            .reset (reset),
            .din   (Interrupt_in[gi]),
            .rise  (rise[gi])
         );
      end
   endgenerate

   // Any decode-stage write suppresses the interrupt ack for this edge;
   // the pending IP bit stays set so fetch sees the request again.
   assign any_write = Status_write | Cause_write | EPC_write;
   assign ack_take  = Interrupt_ack & ~any_write;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         status_q <= 32'h0;
      end else if (Status_write) begin
         status_q <= Status_write_data;
      end else if (ack_take) begin
         status_q[0] <= 1'b0;
      end
   end

   // A new edge always wins over a software clear of the same IP bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cause_q <= 32'h0;
      end else if (Cause_write) begin
         cause_q <= Cause_write_data;
         cause_q[IP_LO +: IRQ_LINES] <= Cause_write_data[IP_LO +: IRQ_LINES] | rise;
      end else begin
         cause_q[IP_LO +: IRQ_LINES] <= cause_q[IP_LO +: IRQ_LINES] | rise;
         if (ack_take)
            cause_q[6:2] <= 5'b00000;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         epc_q <= 32'h0;
      end else if (EPC_write) begin
         epc_q <= EPC_write_data;
      end else if (ack_take) begin
         epc_q <= PC_interrupt;
      end
   end

   assign Status_read_data  = status_q;
   assign Cause_read_data   = cause_q;
   assign EPC_read_data     = epc_q;
   assign Interrupt_request = status_q[0] &
                              (|(cause_q[IP_LO +: IRQ_LINES] & status_q[IP_LO +: IRQ_LINES]));
endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        Status_write = 1'b0;
   logic [31:0] Status_write_data = '0;
   logic        Cause_write = 1'b0;
   logic [31:0] Cause_write_data = '0;
   logic        EPC_write = 1'b0;
   logic [31:0] EPC_write_data = '0;
   logic [5:0]  Interrupt_in = '0;
   logic        Interrupt_ack = 1'b0;
   logic [31:0] PC_interrupt = '0;
   logic [31:0] Status_read_data, Cause_read_data, EPC_read_data;
   logic        Interrupt_request;

   int n_cmp = 0;
   int n_err = 0;

   cp0_regfile #(.IRQ_LINES(6)) dut (
      .clock             (clock),
      .reset             (reset),
      .Status_write      (Status_write),
      .Status_write_data (Status_write_data),
      .Cause_write       (Cause_write),
      .Cause_write_data  (Cause_write_data),
      .EPC_write         (EPC_write),
      .EPC_write_data    (EPC_write_data),
      .Interrupt_in      (Interrupt_in),
      .Interrupt_ack     (Interrupt_ack),
      .PC_interrupt      (PC_interrupt),
      .Status_read_data  (Status_read_data),
      .Cause_read_data   (Cause_read_data),
      .EPC_read_data     (EPC_read_data),
      .Interrupt_request (Interrupt_request)
   );

   always #5 clock = ~clock;

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      Status_write = 0; Cause_write = 0; EPC_write = 0;
      Interrupt_in = '0; Interrupt_ack = 0; PC_interrupt = '0;
      #2 reset = 0;
      #3 reset = 1;
      tick();
   endtask

   task automatic wr_status(input logic [31:0] d);
      Status_write = 1; Status_write_data = d;
      tick();
      Status_write = 0;
   endtask

   task automatic wr_cause(input logic [31:0] d);
      Cause_write = 1; Cause_write_data = d;
      tick();
      Cause_write = 0;
   endtask

   task automatic test_reset();
      // reset is held low from time 0
      #1;
      n_cmp++; if (Status_read_data !== 32'h0) begin n_err++; $display("FAIL reset_status got=%h exp=%h", Status_read_data, 32'h0); end
      n_cmp++; if (Cause_read_data !== 32'h0) begin n_err++; $display("FAIL reset_cause got=%h exp=%h", Cause_read_data, 32'h0); end
      n_cmp++; if (EPC_read_data !== 32'h0) begin n_err++; $display("FAIL reset_epc got=%h exp=%h", EPC_read_data, 32'h0); end
      n_cmp++; if (Interrupt_request !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", Interrupt_request); end
      #8 reset = 1;
      tick();
      // load state, then pull reset mid-cycle
      Status_write = 1; Status_write_data = 32'h0000FC01;
      Cause_write = 1;  Cause_write_data = 32'h0000047C;
      EPC_write = 1;    EPC_write_data = 32'hCAFEF00D;
      tick();
      Status_write = 0; Cause_write = 0; EPC_write = 0;
      n_cmp++; if (Interrupt_request !== 1'b1) begin n_err++; $display("FAIL pre_async_req got=%b exp=1", Interrupt_request); end
      #2 reset = 0;
      #1;
      n_cmp++; if (Status_read_data !== 32'h0) begin n_err++; $display("FAIL async_status got=%h exp=%h", Status_read_data, 32'h0); end
      n_cmp++; if (Cause_read_data !== 32'h0) begin n_err++; $display("FAIL async_cause got=%h exp=%h", Cause_read_data, 32'h0); end
      n_cmp++; if (EPC_read_data !== 32'h0) begin n_err++; $display("FAIL async_epc got=%h exp=%h", EPC_read_data, 32'h0); end
      n_cmp++; if (Interrupt_request !== 1'b0) begin n_err++; $display("FAIL async_req got=%b exp=0", Interrupt_request); end
      #2 reset = 1;
      tick();
      wr_status(32'h0000FC01);
      n_cmp++; if (Status_read_data !== 32'h0000FC01) begin n_err++; $display("FAIL post_reset_status got=%h exp=%h", Status_read_data, 32'h0000FC01); end
   endtask

   task automatic test_latency();
      do_reset();
      wr_status(32'h00000401);
      Interrupt_in[0] = 1;
      tick(); // edge k
      n_cmp++; if (Cause_read_data !== 32'h0 || Interrupt_request !== 1'b0) begin n_err++; $display("FAIL lat_k cause=%h req=%b exp=0/0", Cause_read_data, Interrupt_request); end
      tick(); // edge k+1
      n_cmp++; if (Cause_read_data !== 32'h0 || Interrupt_request !== 1'b0) begin n_err++; $display("FAIL lat_k1 cause=%h req=%b exp=0/0", Cause_read_data, Interrupt_request); end
      tick(); // edge k+2
      n_cmp++; if (Cause_read_data !== 32'h00000400) begin n_err++; $display("FAIL lat_k2_cause got=%h exp=%h", Cause_read_data, 32'h00000400); end
      n_cmp++; if (Interrupt_request !== 1'b1) begin n_err++; $display("FAIL lat_k2_req got=%b exp=1", Interrupt_request); end
   endtask

   task automatic test_masking();
      do_reset();
      wr_status(32'h00000801);
      Interrupt_in[0] = 1;
      ticks(3);
      n_cmp++; if (Cause_read_data !== 32'h00000400) begin n_err++; $display("FAIL mask_cause got=%h exp=%h", Cause_read_data, 32'h00000400); end
      n_cmp++; if (Interrupt_request !== 1'b0) begin n_err++; $display("FAIL mask_req got=%b exp=0", Interrupt_request); end
      Status_write = 1; Status_write_data = 32'h00000C01;
      #1;
      // no bypass: old value until the edge
      n_cmp++; if (Status_read_data !== 32'h00000801 || Interrupt_request !== 1'b0) begin n_err++; $display("FAIL no_bypass status=%h req=%b exp=00000801/0", Status_read_data, Interrupt_request); end
      tick();
      Status_write = 0;
      n_cmp++; if (Interrupt_request !== 1'b1) begin n_err++; $display("FAIL unmask_req got=%b exp=1", Interrupt_request); end
   endtask

   task automatic test_ack();
      do_reset();
      wr_status(32'h0000FC01);
      wr_cause(32'h0000007C);
      Interrupt_in[2] = 1;
      ticks(3);
      n_cmp++; if (Cause_read_data !== 32'h0000107C || Interrupt_request !== 1'b1) begin n_err++; $display("FAIL ack_pre cause=%h req=%b exp=0000107c/1", Cause_read_data, Interrupt_request); end
      Interrupt_ack = 1; PC_interrupt = 32'h00001234;
      tick();
      Interrupt_ack = 0;
      n_cmp++; if (EPC_read_data !== 32'h00001234) begin n_err++; $display("FAIL ack_epc got=%h exp=%h", EPC_read_data, 32'h00001234); end
      n_cmp++; if (Status_read_data !== 32'h0000FC00) begin n_err++; $display("FAIL ack_status got=%h exp=%h", Status_read_data, 32'h0000FC00); end
      n_cmp++; if (Cause_read_data !== 32'h00001000) begin n_err++; $display("FAIL ack_cause got=%h exp=%h", Cause_read_data, 32'h00001000); end
      n_cmp++; if (Interrupt_request !== 1'b0) begin n_err++; $display("FAIL ack_req got=%b exp=0", Interrupt_request); end
   endtask

   task automatic test_conflict();
      do_reset();
      wr_status(32'h0000FC01);
      Interrupt_in[0] = 1;
      ticks(3);
      n_cmp++; if (Cause_read_data !== 32'h00000400) begin n_err++; $display("FAIL conf_pre cause got=%h exp=%h", Cause_read_data, 32'h00000400); end
      Interrupt_ack = 1; PC_interrupt = 32'h00001234;
      Cause_write = 1; Cause_write_data = 32'h00000424;
      EPC_write = 1;   EPC_write_data = 32'h00000100;
      tick();
      Interrupt_ack = 0; Cause_write = 0; EPC_write = 0;
      n_cmp++; if (Cause_read_data !== 32'h00000424) begin n_err++; $display("FAIL conf_cause got=%h exp=%h", Cause_read_data, 32'h00000424); end
      n_cmp++; if (EPC_read_data !== 32'h00000100) begin n_err++; $display("FAIL conf_epc got=%h exp=%h", EPC_read_data, 32'h00000100); end
      n_cmp++; if (Status_read_data !== 32'h0000FC01) begin n_err++; $display("FAIL conf_status got=%h exp=%h", Status_read_data, 32'h0000FC01); end
      n_cmp++; if (Interrupt_request !== 1'b1) begin n_err++; $display("FAIL conf_req got=%b exp=1", Interrupt_request); end
   endtask

   task automatic test_clear_vs_edge();
      do_reset();
      Interrupt_in[0] = 1;
      ticks(3);
      n_cmp++; if (Cause_read_data !== 32'h00000400) begin n_err++; $display("FAIL clr_pre got=%h exp=%h", Cause_read_data, 32'h00000400); end
      wr_cause(32'h0);
      n_cmp++; if (Cause_read_data !== 32'h0) begin n_err++; $display("FAIL clr_ip0 got=%h exp=%h", Cause_read_data, 32'h0); end
      // line 0 still high: no further set
      ticks(3);
      n_cmp++; if (Cause_read_data !== 32'h0) begin n_err++; $display("FAIL held_once got=%h exp=%h", Cause_read_data, 32'h0); end
      Interrupt_in[1] = 1;
      ticks(2);            // edge k, k+1: rise[1] now high
      wr_cause(32'h0);     // clear lands on edge k+2 with the edge
      n_cmp++; if (Cause_read_data !== 32'h00000800) begin n_err++; $display("FAIL set_wins got=%h exp=%h", Cause_read_data, 32'h00000800); end
      wr_cause(32'h0);
      Interrupt_in[1] = 0;
      ticks(3);
      Interrupt_in[1] = 1;
      ticks(2);
      n_cmp++; if (Cause_read_data !== 32'h0) begin n_err++; $display("FAIL rerise_early got=%h exp=%h", Cause_read_data, 32'h0); end
      tick();
      n_cmp++; if (Cause_read_data !== 32'h00000800) begin n_err++; $display("FAIL rerise got=%h exp=%h", Cause_read_data, 32'h00000800); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      Status_write = 1; Status_write_data = 32'hFFFF0301;
      Cause_write = 1;  Cause_write_data = 32'hA5A503FC;
      EPC_write = 1;    EPC_write_data = 32'hDEADBEEF;
      tick();
      Status_write = 0; EPC_write = 0;
      Cause_write_data = 32'h0000FC00;
      n_cmp++; if (Status_read_data !== 32'hFFFF0301 || Cause_read_data !== 32'hA5A503FC || EPC_read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_all s=%h c=%h e=%h exp=ffff0301/a5a503fc/deadbeef", Status_read_data, Cause_read_data, EPC_read_data); end
      n_cmp++; if (Interrupt_request !== 1'b0) begin n_err++; $display("FAIL b2b_req got=%b exp=0", Interrupt_request); end
      tick();
      Cause_write = 0;
      n_cmp++; if (Cause_read_data !== 32'h0000FC00 || Status_read_data !== 32'hFFFF0301 || EPC_read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_cause s=%h c=%h e=%h exp=ffff0301/0000fc00/deadbeef", Status_read_data, Cause_read_data, EPC_read_data); end
      n_cmp++; if (Interrupt_request !== 1'b0) begin n_err++; $display("FAIL b2b_req_masked got=%b exp=0", Interrupt_request); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_masking();
      test_ack();
      test_conflict();
      test_clear_vs_edge();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
